counting_the_world: RTL and testbench



---
 rtl/counting_the_world.sv | 36 +++
 tb/tb_counting_the_world.sv | 101 ++++++++++
 2 files changed

// File: rtl/counting_the_world.sv
// counting_the_world: push-button clocked up-counter shown directly on the LED bank.
// The slide switch clears the count synchronously and takes priority over counting.
module counting_the_world #(
  parameter int WIDTH    = 16,
  parameter int STEP     = 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic             pushButton,
  input  logic             slideSwitch,
  output logic [WIDTH-1:0] LEDS
);

  // One extra bit on the adder exposes the carry-out, so overflow is a single bit test.
  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  // Power-up value is zero so the LEDs are defined before the switch is ever used.
  logic [WIDTH-1:0] count = '0;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] countNext;

  // Next count: truncating add, or clamp to all-ones when saturation is enabled.
  always_comb begin
    sum       = {1'b0, count} + STEP_EXT;
    countNext = sum[WIDTH-1:0];
    if (SATURATE && sum[WIDTH]) countNext = '1;
  end

  // Count register: the slide switch wins over counting on the same edge.
  always_ff @(posedge pushButton) begin
    if (slideSwitch) count <= '0;
    else             count <= countNext;
  end

  assign LEDS = count;

endmodule

// File: tb/tb_counting_the_world.sv
// Bench for counting_the_world: three instances (wrap, saturate, STEP=3) share clock and reset.
module tb_counting_the_world;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] ledsWrap, ledsSat, ledsStep3;

  int vectors     = 0;
  int miscompares = 0;

  // Model: number of counting edges since the last reset edge; outputs follow arithmetically.
  longint edgesSinceReset = 0;

  counting_the_world #(.WIDTH(16), .STEP(1), .SATURATE(1'b0)) uWrap (
    .pushButton(clk), .slideSwitch(rst), .LEDS(ledsWrap));
  counting_the_world #(.WIDTH(16), .STEP(1), .SATURATE(1'b1)) uSat (
    .pushButton(clk), .slideSwitch(rst), .LEDS(ledsSat));
  counting_the_world #(.WIDTH(16), .STEP(3), .SATURATE(1'b0)) uStep3 (
    .pushButton(clk), .slideSwitch(rst), .LEDS(ledsStep3));

  // Rising edges at 10, 30, 50, ... ns.
  always #10 clk = ~clk;

  function automatic logic [15:0] expWrap(longint n, longint step);
    return 16'((n * step) % 65536);
  endfunction

  function automatic logic [15:0] expSat(longint n, longint step);
    return (n * step > 65535) ? 16'hFFFF : 16'(n * step);
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) edgesSinceReset <= 0;
    else     edgesSinceReset <= edgesSinceReset + 1;
  end

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    check("model_wrap",  ledsWrap,  expWrap(edgesSinceReset, 1));
    check("model_sat",   ledsSat,   expSat(edgesSinceReset, 1));
    check("model_step3", ledsStep3, expWrap(edgesSinceReset, 3));
  end

  // Directed vectors with hand-computed literal expectations.
  initial begin
    #5;
    check("powerup_wrap",  ledsWrap,  16'h0000);
    check("powerup_step3", ledsStep3, 16'h0000);
    #190;                                       // 195 ns
    check("run10_wrap", ledsWrap, 16'h000A);
    check("run10_sat",  ledsSat,  16'h000A);
    #5  rst = 1'b1;                             // 200 ns
    #50 check("rst_mid",  ledsWrap, 16'h0000);  // 250 ns
    #45 check("rst_end",  ledsWrap, 16'h0000);  // 295 ns
    #5  rst = 1'b0;                             // 300 ns
    #15 check("resume1",  ledsWrap, 16'h0001);  // 315 ns
    #20 check("resume2",  ledsWrap, 16'h0002);  // 335 ns
    #40 check("step3_x4", ledsStep3, 16'h000C); // 375 ns
    check("resume4",  ledsWrap, 16'h0004);
    #20 check("resume5",  ledsWrap, 16'h0005);  // 395 ns
    // Reset pulse entirely between the 390 and 410 ns edges.
    #10 rst = 1'b1;                             // 405 ns
    #2  rst = 1'b0;                             // 407 ns
    #8  check("glitch_ignored", ledsWrap, 16'h0006); // 415 ns
    check("glitch_step3", ledsStep3, 16'h0012);
    // Clear, then 65535 counting edges up to the top of the range.
    #5  rst = 1'b1;                             // 420 ns
    #20 rst = 1'b0;                             // 440 ns
    check("cleared", ledsWrap, 16'h0000);
    repeat (65535) @(posedge clk);
    #5;
    check("top_wrap",  ledsWrap,  16'hFFFF);
    check("top_sat",   ledsSat,   16'hFFFF);
    check("top_step3", ledsStep3, 16'hFFFD);
    @(posedge clk); #5;
    check("wrap_to_zero", ledsWrap,  16'h0000);
    check("sat_hold",     ledsSat,   16'hFFFF);
    check("step3_wrap",   ledsStep3, 16'h0000);
    repeat (2) @(posedge clk); #5;
    check("wrap_after",   ledsWrap, 16'h0002);
    check("sat_hold2",    ledsSat,  16'hFFFF);
    // Saturated counter leaves all-ones only through reset.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("sat_reset", ledsSat, 16'h0000);
    @(posedge clk); #5;
    check("sat_restart", ledsSat, 16'h0001);
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
